// File: rtl/hist_ctrl.sv
// Frame-level controller for a histogram engine: streams pixels row by row,
// then forwards 256 result bins and checks their total against the frame size.
module hist_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [9:0]  cfg_rows,
    input  logic [9:0]  cfg_cols,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        h_start,
    output logic [7:0]  h_din,
    output logic        h_din_vld,
    input  logic        h_init_done,
    input  logic        h_cal_row_done,
    input  logic        h_dout_vld,
    input  logic [19:0] h_dout,
    output logic [7:0]  bin_idx,
    output logic [19:0] bin_cnt,
    output logic        bin_vld,
    output logic        hist_done,
    output logic        busy,
    output logic        cfg_err,
    output logic        sum_err
);

    localparam int unsigned DIM_W = 10;
    localparam int unsigned PIX_W = 8;
    localparam int unsigned CNT_W = 20;
    localparam int unsigned ACC_W = 21;
    localparam int unsigned BIN_W = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INIT     = 3'd1,
        ROW      = 3'd2,
        ROW_WAIT = 3'd3,
        READ     = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [DIM_W-1:0]   cfg_rows_q;
    logic [DIM_W-1:0]   cfg_cols_q;
    logic [DIM_W-1:0]   col_cnt;
    logic [DIM_W-1:0]   row_cnt;
    logic [BIN_W-1:0]   bin_ctr;
    logic [ACC_W-1:0]   acc;
    logic               init_d;

    logic               accept_c;
    logic               reject_c;
    logic               xfer_c;
    logic               col_last_c;
    logic               row_done_c;
    logic               beat_c;
    logic               last_bin_c;
    logic [ACC_W-1:0]   acc_sum_c;
    logic [CNT_W-1:0]   product_c;

    assign col_last_c = (col_cnt == DIM_W'(cfg_cols_q - DIM_W'(1)));
    assign acc_sum_c  = acc + ACC_W'(h_dout);
    assign product_c  = CNT_W'(cfg_rows_q) * CNT_W'(cfg_cols_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle strobes
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        reject_c   = 1'b0;
        xfer_c     = 1'b0;
        row_done_c = 1'b0;
        beat_c     = 1'b0;
        last_bin_c = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    if ((cfg_rows != '0) && (cfg_cols != '0)) begin
                        accept_c   = 1'b1;
                        state_next = INIT;
                    end else begin
                        reject_c = 1'b1;
                    end
                end
            end
            INIT: begin
                if (init_d && !h_init_done) begin
                    state_next = ROW;
                end
            end
            ROW: begin
                if (s_valid) begin
                    xfer_c = 1'b1;
                    if (col_last_c) begin
                        state_next = ROW_WAIT;
                    end
                end
            end
            ROW_WAIT: begin
                if (h_cal_row_done) begin
                    row_done_c = 1'b1;
                    state_next = (DIM_W'(row_cnt + DIM_W'(1)) == cfg_rows_q) ? READ : ROW;
                end
            end
            READ: begin
                if (h_dout_vld) begin
                    beat_c = 1'b1;
                    if (bin_ctr == BIN_W'(255)) begin
                        last_bin_c = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath, counters and registered outputs; s_ready/busy track the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_rows_q <= '0;
            cfg_cols_q <= '0;
            col_cnt    <= '0;
            row_cnt    <= '0;
            bin_ctr    <= '0;
            acc        <= '0;
            init_d     <= 1'b0;
            s_ready    <= 1'b0;
            h_start    <= 1'b0;
            h_din      <= '0;
            h_din_vld  <= 1'b0;
            bin_idx    <= '0;
            bin_cnt    <= '0;
            bin_vld    <= 1'b0;
            hist_done  <= 1'b0;
            busy       <= 1'b0;
            cfg_err    <= 1'b0;
            sum_err    <= 1'b0;
        end else begin
            init_d    <= h_init_done;
            h_start   <= accept_c;
            cfg_err   <= reject_c;
            s_ready   <= (state_next == ROW);
            busy      <= (state_next != IDLE);
            h_din_vld <= xfer_c;
            bin_vld   <= beat_c;
            hist_done <= last_bin_c;

            if (accept_c) begin
                cfg_rows_q <= cfg_rows;
                cfg_cols_q <= cfg_cols;
                col_cnt    <= '0;
                row_cnt    <= '0;
                bin_ctr    <= '0;
                acc        <= '0;
                sum_err    <= 1'b0;
            end

            if (xfer_c) begin
                h_din   <= PIX_W'(s_data);
                col_cnt <= col_last_c ? '0 : DIM_W'(col_cnt + DIM_W'(1));
            end

            if (row_done_c) begin
                row_cnt <= DIM_W'(row_cnt + DIM_W'(1));
            end

            if (beat_c) begin
                bin_idx <= bin_ctr;
                bin_cnt <= h_dout;
                bin_ctr <= BIN_W'(bin_ctr + BIN_W'(1));
                acc     <= acc_sum_c;
            end

            // Total of all bins must equal pixels per frame
            if (last_bin_c) begin
                sum_err <= (acc_sum_c != ACC_W'(product_c));
            end
        end
    end

endmodule

// File: tb/tb_hist_ctrl.sv
// Directed bench for hist_ctrl: a per-cycle vector table for a small frame,
// then multi-cycle sequences for full frames, sum errors, throttling and reset.
module tb_hist_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [9:0]  cfg_rows;
    logic [9:0]  cfg_cols;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        h_start;
    logic [7:0]  h_din;
    logic        h_din_vld;
    logic        h_init_done;
    logic        h_cal_row_done;
    logic        h_dout_vld;
    logic [19:0] h_dout;
    logic [7:0]  bin_idx;
    logic [19:0] bin_cnt;
    logic        bin_vld;
    logic        hist_done;
    logic        busy;
    logic        cfg_err;
    logic        sum_err;

    int          n_vec = 0;
    int          n_err = 0;
    int          rw_cnt = 0;
    logic [7:0]  last_d = 8'h00;

    hist_ctrl dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .h_start(h_start), .h_din(h_din), .h_din_vld(h_din_vld),
        .h_init_done(h_init_done), .h_cal_row_done(h_cal_row_done),
        .h_dout_vld(h_dout_vld), .h_dout(h_dout),
        .bin_idx(bin_idx), .bin_cnt(bin_cnt), .bin_vld(bin_vld),
        .hist_done(hist_done), .busy(busy), .cfg_err(cfg_err), .sum_err(sum_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct packed {
        logic       rst;
        logic       fs;
        logic [9:0] rows;
        logic [9:0] cols;
        logic       sv;
        logic [7:0] sd;
        logic       ini;
        logic       rdone;
        logic       dv;
        logic       e_rdy;
        logic       e_hst;
        logic       e_hvld;
        logic [7:0] e_hdin;
        logic       e_busy;
        logic       e_cerr;
        logic       e_bvld;
    } vec_t;

    vec_t tbl [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_ready"},   32'(s_ready),   0);
        chk({tag, "_h_start"},   32'(h_start),   0);
        chk({tag, "_h_din_vld"}, 32'(h_din_vld), 0);
        chk({tag, "_h_din"},     32'(h_din),     0);
        chk({tag, "_bin_vld"},   32'(bin_vld),   0);
        chk({tag, "_bin_idx"},   32'(bin_idx),   0);
        chk({tag, "_bin_cnt"},   32'(bin_cnt),   0);
        chk({tag, "_hist_done"}, 32'(hist_done), 0);
        chk({tag, "_busy"},      32'(busy),      0);
        chk({tag, "_cfg_err"},   32'(cfg_err),   0);
        chk({tag, "_sum_err"},   32'(sum_err),   0);
    endtask

    task automatic start_frame(input logic [9:0] rows, input logic [9:0] cols);
        frame_start = 1'b1;
        cfg_rows    = rows;
        cfg_cols    = cols;
        h_init_done = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("accept_h_start", 32'(h_start), 1);
        chk("accept_busy",    32'(busy),    1);
        chk("accept_sum_err", 32'(sum_err), 0);
        chk("accept_s_ready", 32'(s_ready), 0);
        tick();
        chk("init_h_start",   32'(h_start), 0);
        chk("init_s_ready",   32'(s_ready), 0);
        h_init_done = 1'b0;
        tick();
        chk("row_entry_s_ready", 32'(s_ready), 1);
    endtask

    // Stream one row; the bench counts transfers itself and expects s_ready to drop after cols
    task automatic stream_row(input int cols, input bit half, input bit repulse);
        int n = 0;
        int cyc = 0;
        logic [7:0] d;
        while (n < cols && cyc < 4 * cols + 8) begin
            chk("row_s_ready", 32'(s_ready), 1);
            s_valid = half ? ((cyc % 2) == 0) : 1'b1;
            d = 8'($urandom);
            s_data = d;
            if (repulse && cyc == 3) begin
                frame_start = 1'b1;
                cfg_rows    = 10'd1;
                cfg_cols    = 10'd1;
            end
            tick();
            if (frame_start) begin
                frame_start = 1'b0;
                chk("repulse_h_start", 32'(h_start), 0);
                chk("repulse_cfg_err", 32'(cfg_err), 0);
            end
            if (s_valid) begin
                n++;
                last_d = d;
                chk("row_h_din_vld", 32'(h_din_vld), 1);
            end else begin
                chk("row_h_din_vld_idle", 32'(h_din_vld), 0);
            end
            chk("row_h_din", 32'(h_din), 32'(last_d));
            cyc++;
        end
        s_valid = 1'b0;
        chk("row_end_s_ready", 32'(s_ready), 0);
    endtask

    task automatic row_wait(input bit last);
        tick();
        chk("rw_s_ready", 32'(s_ready), 0);
        chk("rw_busy",    32'(busy),    1);
        h_cal_row_done = 1'b1;
        tick();
        h_cal_row_done = 1'b0;
        chk("rw_exit_s_ready", 32'(s_ready), last ? 0 : 1);
        rw_cnt++;
    endtask

    task automatic read_bins(input int per, input int nz, input int bad, input logic exp_err);
        logic [19:0] v;
        for (int b = 0; b < 256; b++) begin
            if ((b % 37) == 3) begin
                h_dout_vld = 1'b0;
                h_dout     = 20'hABCDE;
                tick();
                chk("gap_bin_vld", 32'(bin_vld), 0);
            end
            v = 20'((b < nz) ? per : 0) + 20'((b == bad) ? 1 : 0);
            h_dout_vld = 1'b1;
            h_dout     = v;
            tick();
            h_dout_vld = 1'b0;
            chk("bin_vld", 32'(bin_vld), 1);
            chk("bin_idx", 32'(bin_idx), 32'(b));
            chk("bin_cnt", 32'(bin_cnt), 32'(v));
            if (b == 255) begin
                chk("done_hist_done", 32'(hist_done), 1);
                chk("done_sum_err",   32'(sum_err),   32'(exp_err));
                chk("done_busy",      32'(busy),      1);
            end else if ((b % 64) == 0) begin
                chk("read_hist_done", 32'(hist_done), 0);
            end
        end
        tick();
        chk("post_hist_done", 32'(hist_done), 0);
        chk("post_busy",      32'(busy),      0);
        chk("post_bin_vld",   32'(bin_vld),   0);
        chk("post_sum_err",   32'(sum_err),   32'(exp_err));
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; cfg_rows = '0; cfg_cols = '0;
        s_data = '0; s_valid = 1'b0; h_init_done = 1'b0; h_cal_row_done = 1'b0;
        h_dout_vld = 1'b0; h_dout = 20'd7;

        //          rst fs rows   cols   sv sd     ini rd dv | rdy hst hvld hdin   busy cerr bvld
        tbl[0]  = '{1, 0, 10'd0, 10'd0, 0, 8'h00, 0, 0, 0,   0,  0,  0,   8'h00, 0,   0,   0};
        tbl[1]  = '{0, 1, 10'd3, 10'd0, 0, 8'h00, 0, 0, 0,   0,  0,  0,   8'h00, 0,   1,   0};
        tbl[2]  = '{0, 0, 10'd3, 10'd0, 0, 8'h00, 0, 0, 0,   0,  0,  0,   8'h00, 0,   0,   0};
        tbl[3]  = '{0, 1, 10'd0, 10'd4, 0, 8'h00, 0, 0, 0,   0,  0,  0,   8'h00, 0,   1,   0};
        tbl[4]  = '{0, 1, 10'd1, 10'd4, 0, 8'h00, 1, 0, 0,   0,  1,  0,   8'h00, 1,   0,   0};
        tbl[5]  = '{0, 0, 10'd0, 10'd0, 0, 8'h00, 1, 0, 0,   0,  0,  0,   8'h00, 1,   0,   0};
        tbl[6]  = '{0, 0, 10'd0, 10'd0, 0, 8'h00, 0, 0, 0,   1,  0,  0,   8'h00, 1,   0,   0};
        tbl[7]  = '{0, 1, 10'd0, 10'd0, 1, 8'h11, 0, 0, 0,   1,  0,  1,   8'h11, 1,   0,   0};
        tbl[8]  = '{0, 0, 10'd0, 10'd0, 0, 8'h22, 0, 0, 0,   1,  0,  0,   8'h11, 1,   0,   0};
        tbl[9]  = '{0, 0, 10'd0, 10'd0, 1, 8'h33, 0, 1, 0,   1,  0,  1,   8'h33, 1,   0,   0};
        tbl[10] = '{0, 0, 10'd0, 10'd0, 1, 8'h44, 0, 0, 0,   1,  0,  1,   8'h44, 1,   0,   0};
        tbl[11] = '{0, 0, 10'd0, 10'd0, 1, 8'h55, 0, 0, 0,   0,  0,  1,   8'h55, 1,   0,   0};
        tbl[12] = '{0, 0, 10'd0, 10'd0, 1, 8'h66, 0, 0, 1,   0,  0,  0,   8'h55, 1,   0,   0};
        tbl[13] = '{0, 0, 10'd0, 10'd0, 0, 8'h00, 0, 1, 0,   0,  0,  0,   8'h55, 1,   0,   0};

        // 1x4 frame cycle by cycle, with cfg changed and stray pulses while busy
        for (int i = 0; i < 14; i++) begin
            rst            = tbl[i].rst;
            frame_start    = tbl[i].fs;
            cfg_rows       = tbl[i].rows;
            cfg_cols       = tbl[i].cols;
            s_valid        = tbl[i].sv;
            s_data         = tbl[i].sd;
            h_init_done    = tbl[i].ini;
            h_cal_row_done = tbl[i].rdone;
            h_dout_vld     = tbl[i].dv;
            tick();
            chk($sformatf("v%0d_s_ready", i),   32'(s_ready),   32'(tbl[i].e_rdy));
            chk($sformatf("v%0d_h_start", i),   32'(h_start),   32'(tbl[i].e_hst));
            chk($sformatf("v%0d_h_din_vld", i), 32'(h_din_vld), 32'(tbl[i].e_hvld));
            chk($sformatf("v%0d_h_din", i),     32'(h_din),     32'(tbl[i].e_hdin));
            chk($sformatf("v%0d_busy", i),      32'(busy),      32'(tbl[i].e_busy));
            chk($sformatf("v%0d_cfg_err", i),   32'(cfg_err),   32'(tbl[i].e_cerr));
            chk($sformatf("v%0d_bin_vld", i),   32'(bin_vld),   32'(tbl[i].e_bvld));
            if (tbl[i].rst) chk_all_zero("reset");
        end
        rst = 1'b0; frame_start = 1'b0; s_valid = 1'b0;
        h_cal_row_done = 1'b0; h_dout_vld = 1'b0;
        read_bins(1, 4, -1, 1'b0);

        // 5x256 frame, bins sum to 1280
        rw_cnt = 0;
        start_frame(10'd5, 10'd256);
        for (int r = 0; r < 5; r++) begin
            stream_row(256, 1'b0, 1'b0);
            row_wait(r == 4);
        end
        chk("row_wait_count", 32'(rw_cnt), 5);
        read_bins(5, 256, -1, 1'b0);

        // Same frame with bin 5 one too high; sum_err holds until an accepted start
        start_frame(10'd5, 10'd256);
        for (int r = 0; r < 5; r++) begin
            stream_row(256, 1'b0, 1'b0);
            row_wait(r == 4);
        end
        read_bins(5, 256, 5, 1'b1);
        tick();
        tick();
        chk("sum_err_hold", 32'(sum_err), 1);
        frame_start = 1'b1; cfg_rows = 10'd2; cfg_cols = 10'd0;
        tick();
        frame_start = 1'b0;
        chk("reject_cfg_err", 32'(cfg_err), 1);
        chk("reject_busy",    32'(busy),    0);
        chk("reject_sum_err", 32'(sum_err), 1);
        tick();
        chk("reject_cfg_err_pulse", 32'(cfg_err), 0);

        // 2x8 frame, 50% s_valid, frame_start re-pulsed mid-row
        start_frame(10'd2, 10'd8);
        stream_row(8, 1'b1, 1'b1);
        row_wait(1'b0);
        stream_row(8, 1'b1, 1'b0);
        row_wait(1'b1);
        read_bins(1, 16, -1, 1'b0);

        // Reset during row 2 of a 3x4 frame, then a clean 1x4 frame
        start_frame(10'd3, 10'd4);
        stream_row(4, 1'b0, 1'b0);
        row_wait(1'b0);
        s_valid = 1'b1; s_data = 8'h5A;
        tick();
        tick();
        rst = 1'b1; s_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk_all_zero("midrst");
        tick();
        tick();
        chk("midrst_idle_busy",      32'(busy),      0);
        chk("midrst_idle_hist_done", 32'(hist_done), 0);
        chk("midrst_idle_s_ready",   32'(s_ready),   0);
        last_d = 8'h00;
        start_frame(10'd1, 10'd4);
        stream_row(4, 1'b0, 1'b0);
        row_wait(1'b1);
        read_bins(1, 4, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hist_ctrl.md
HIST_CTRL -- requirements
Module: hist_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-002 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-003 SHALL have port frame_start, input, 1: one-cycle request to histogram one frame.
REQ-004 SHALL have ports cfg_rows and cfg_cols, inputs, 10 each: rows per frame and pixels per row, sampled on accepted frame_start.
REQ-005 SHALL have ports s_data (input, 8), s_valid (input, 1) and s_ready (output, 1): upstream pixel stream.
REQ-006 SHALL have ports h_start (output, 1), h_din (output, 8) and h_din_vld (output, 1): histogram engine command/data.
REQ-007 SHALL have ports h_init_done, h_cal_row_done and h_dout_vld (inputs, 1 each) and h_dout (input, 20): histogram engine status/results.
REQ-008 SHALL have ports bin_idx (output, 8), bin_cnt (output, 20) and bin_vld (output, 1): forwarded result bins.
REQ-009 SHALL have ports hist_done (output, 1), busy (output, 1), cfg_err (output, 1) and sum_err (output, 1): status.

Function
REQ-010 SHALL implement states IDLE, INIT, ROW, ROW_WAIT, READ, DONE.
REQ-011 In IDLE, on frame_start with cfg_rows!=0 and cfg_cols!=0, SHALL latch both cfg values, drive h_start=1 for exactly the next cycle, and enter INIT.
REQ-012 In IDLE, on frame_start with cfg_rows==0 or cfg_cols==0, SHALL pulse cfg_err for 1 cycle and stay in IDLE.
REQ-013 INIT SHALL wait for a falling edge of h_init_done (registered prior value 1, current 0), then enter ROW with col_cnt=0 and row_cnt=0.
REQ-014 s_ready SHALL be 1 only in ROW; a transfer occurs when s_valid and s_ready are both 1.
REQ-015 Each transfer SHALL produce h_din=s_data and h_din_vld=1 on the following cycle (1-cycle registered latency); otherwise h_din_vld=0 and h_din holds its value.
REQ-016 col_cnt SHALL increment per transfer; on the transfer with col_cnt==cfg_cols-1, SHALL clear col_cnt and enter ROW_WAIT, so s_ready is 0 on the next cycle.
REQ-017 ROW_WAIT SHALL wait for h_cal_row_done=1, then increment row_cnt; if the new row_cnt==cfg_rows, enter READ, else enter ROW.
REQ-018 An h_cal_row_done pulse outside ROW_WAIT SHALL be ignored.
REQ-019 In READ, each cycle with h_dout_vld=1 SHALL produce, on the next cycle, bin_vld=1, bin_cnt=h_dout and bin_idx=bin counter (0..255); the bin counter then increments.
REQ-020 READ SHALL add each h_dout into a 21-bit accumulator cleared on frame accept; after bin 255 is forwarded, SHALL enter DONE.
REQ-021 DONE SHALL last 1 cycle, pulse hist_done=1 and set sum_err=1 if accumulator != cfg_rows*cfg_cols (20-bit unsigned product, max 1046529); then return to IDLE.
REQ-022 sum_err SHALL hold its value until the next accepted frame_start, which clears it.
REQ-023 h_dout_vld outside READ SHALL be ignored; bins beyond 255 cannot occur since READ exits after 256 beats.
REQ-024 busy SHALL be 1 in every state except IDLE; frame_start while busy SHALL be ignored with no effect on latched cfg.
REQ-025 cfg_rows/cfg_cols changes after frame accept SHALL NOT affect the running frame.

Reset
REQ-026 On rst=1 at a clock edge SHALL enter IDLE and clear all counters, accumulator and init_done edge register.
REQ-027 Reset SHALL drive s_ready, h_start, h_din_vld, bin_vld, hist_done, busy, cfg_err and sum_err to 0, and h_din, bin_idx and bin_cnt to 0.
REQ-028 Reset asserted mid-frame (any state) SHALL abort the frame with no hist_done; the next frame SHALL require a new frame_start.

Verification
REQ-029 Scenario: cfg 5x256, frame_start, h_init_done 1->0, random s_data with s_valid always 1 -> exactly 256 s_ready-high cycles per row, h_din_vld mirrors each transfer 1 cycle late, and 5 ROW_WAIT periods occur.
REQ-030 Scenario: after the 5th row, engine model emits 256 h_dout beats summing to 1280 -> bin_idx 0..255 sequential, hist_done pulse, sum_err=0.
REQ-031 Scenario: same as REQ-030 but bin 5 count off by +1 (sum 1281) -> hist_done pulse with sum_err=1, held until next frame_start.
REQ-032 Scenario: frame_start with cfg_cols=0 -> cfg_err pulse 1 cycle, h_start never asserted, busy=0.
REQ-033 Scenario: s_valid toggled 50% and frame_start re-pulsed mid-row -> column counts still exactly cfg_cols per row and the re-pulse is ignored.
REQ-034 Scenario: rst=1 for 1 cycle during row 2 -> next cycle all outputs 0, state IDLE; a new 1x4 frame then completes normally.
